// File: rtl/fetch_ctrl_pkg.sv
// Shared types and defaults for the instruction fetch controller.
package fetch_ctrl_pkg;

  // Default fetch address width, reset vector and PC stride (bytes).
  localparam int          FC_ADDR_W   = 32;
  localparam logic [31:0] FC_RESET_PC = 32'h0000_0000;
  localparam int          FC_INST_B   = 4;

  // RUN: IF shows mem_rdata directly. HOLD: IF shows the held instruction.
  typedef enum logic {
    FC_RUN  = 1'b0,
    FC_HOLD = 1'b1
  } fc_state_e;

endpackage

// File: rtl/fetch_ctrl_dff.sv
// Generic register cell: rising-edge D flop with synchronous active-high reset.
module fetch_ctrl_dff #(
  parameter int         W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load the reset value when rst is sampled high, else capture d.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage fetch sequencer: owns the fetch PC, issues single-outstanding
// requests to the shared instruction port, and steers the IF hold register
// so a stalled instruction survives changes on mem_rdata.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = FC_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FC_RESET_PC),
  parameter int                INST_B   = FC_INST_B
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  output logic              inst_CE,
  output logic              inst_sel,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] inst_pc
);

  logic [ADDR_W-1:0] fetch_pc_d, fetch_pc_q;
  logic [ADDR_W-1:0] resp_pc_d, resp_pc_q;
  logic              resp_pend_d, resp_pend_q;
  fc_state_e         st_d;
  logic              st_q;

  fetch_ctrl_dff #(.W(ADDR_W), .RST_VAL(RESET_PC)) u_fetch_pc (
    .clk(clk), .rst(rst), .d(fetch_pc_d), .q(fetch_pc_q)
  );

  fetch_ctrl_dff #(.W(ADDR_W), .RST_VAL(RESET_PC)) u_resp_pc (
    .clk(clk), .rst(rst), .d(resp_pc_d), .q(resp_pc_q)
  );

  fetch_ctrl_dff #(.W(1), .RST_VAL(1'b0)) u_resp_pend (
    .clk(clk), .rst(rst), .d(resp_pend_d), .q(resp_pend_q)
  );

  fetch_ctrl_dff #(.W(1), .RST_VAL(1'(FC_RUN))) u_st (
    .clk(clk), .rst(rst), .d(st_d), .q(st_q)
  );

  logic              pres;
  logic              consume;
  logic              req_int;
  logic [ADDR_W-1:0] addr_int;
  logic              acc;
  fc_state_e         st_cur;

  // Next-state and output logic; reset forces every output to its idle value.
  always_comb begin
    st_cur     = fc_state_e'(st_q);
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    resp_pend_d = 1'b0;
    st_d       = st_cur;

    // An instruction is in IF either fresh from memory or from the hold register.
    pres     = ((st_cur == FC_RUN) && resp_pend_q) || (st_cur == FC_HOLD);
    consume  = pres && !stall && !jump_en;
    req_int  = jump_en || !pres || consume;
    addr_int = jump_en ? jump_addr : fetch_pc_q;
    acc      = req_int && mem_gnt;

    if (acc) begin
      resp_pc_d   = addr_int;
      fetch_pc_d  = addr_int + ADDR_W'(INST_B);
      resp_pend_d = 1'b1;
    end else if (jump_en) begin
      // Ungranted redirect: remember the target so the retry goes there.
      fetch_pc_d = jump_addr;
    end

    if (jump_en) begin
      st_d = FC_RUN;
    end else if ((st_cur == FC_RUN) && resp_pend_q && stall) begin
      st_d = FC_HOLD;
    end else if ((st_cur == FC_HOLD) && !stall) begin
      st_d = FC_RUN;
    end

    mem_req    = req_int;
    mem_addr   = addr_int;
    inst_CE    = (st_cur == FC_RUN) && resp_pend_q && stall && !jump_en;
    inst_sel   = (st_cur == FC_HOLD);
    inst_valid = pres && !jump_en;
    inst_pc    = resp_pc_q;

    if (rst) begin
      mem_req    = 1'b0;
      mem_addr   = RESET_PC;
      inst_CE    = 1'b0;
      inst_sel   = 1'b0;
      inst_valid = 1'b0;
      inst_pc    = RESET_PC;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: an abstract "what sits in IF" model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_fetch_ctrl;

  localparam int          AW  = 32;
  localparam logic [31:0] RPC = 32'h0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic          jump_en = 1'b0;
  logic [AW-1:0] jump_addr = '0;
  logic          mem_gnt = 1'b1;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          inst_CE;
  logic          inst_sel;
  logic          inst_valid;
  logic [AW-1:0] inst_pc;

  int total = 0;
  int bad   = 0;

  fetch_ctrl #(.ADDR_W(AW), .RESET_PC(RPC), .INST_B(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .jump_en(jump_en), .jump_addr(jump_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .inst_CE(inst_CE), .inst_sel(inst_sel), .inst_valid(inst_valid), .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Abstract model: is there an instruction in IF, has it been held across
  // a stall, which PC it has, and which address is fetched next.
  bit            m_have = 0;
  bit            m_held = 0;
  logic [AW-1:0] m_pc   = RPC;
  logic [AW-1:0] m_next = RPC;

  // Advance the model on each rising edge using the inputs of the ending cycle.
  always @(posedge clk) begin
    bit            want;
    logic [AW-1:0] where;
    if (rst) begin
      m_have = 0; m_held = 0; m_pc = RPC; m_next = RPC;
    end else begin
      want  = jump_en || !m_have || !stall;
      where = jump_en ? jump_addr : m_next;
      if (want && mem_gnt) begin
        $display("fetch accepted addr=%h", where);
        m_have = 1; m_held = 0; m_pc = where; m_next = where + 4;
      end else if (jump_en) begin
        m_have = 0; m_held = 0; m_next = jump_addr;
      end else if (m_have && stall) begin
        m_held = 1;
      end else begin
        m_have = 0; m_held = 0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (rst) begin
      chk("m_req", mem_req, 0);
      chk("m_ce", inst_CE, 0);
      chk("m_sel", inst_sel, 0);
      chk("m_valid", inst_valid, 0);
      chk("m_addr", mem_addr, RPC);
      chk("m_pc", inst_pc, RPC);
    end else begin
      chk("m_req", mem_req, jump_en || !m_have || !stall);
      chk("m_addr", mem_addr, jump_en ? jump_addr : m_next);
      chk("m_valid", inst_valid, m_have && !jump_en);
      chk("m_ce", inst_CE, m_have && !m_held && stall && !jump_en);
      chk("m_sel", inst_sel, m_held);
      if (m_have) chk("m_pc", inst_pc, m_pc);
    end
  end

  // Drive one cycle's inputs just after the rising edge, then move to mid-cycle.
  task automatic cyc(input logic r, input logic s, input logic j,
                     input logic [AW-1:0] ja, input logic g);
    @(posedge clk);
    #1;
    rst = r; stall = s; jump_en = j; jump_addr = ja; mem_gnt = g;
    @(negedge clk);
    #1;
  endtask

  initial begin
    // Reset held for two cycles
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    chk("rst_req", mem_req, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_addr", mem_addr, 32'h0);

    // 1: streaming after reset release
    cyc(0, 0, 0, 0, 1);
    chk("s1_addr0", mem_addr, 32'h0);
    chk("s1_valid0", inst_valid, 0);
    cyc(0, 0, 0, 0, 1);
    chk("s1_addr1", mem_addr, 32'h4);
    chk("s1_pc0", inst_pc, 32'h0);
    chk("s1_valid1", inst_valid, 1);
    cyc(0, 0, 0, 0, 1);
    chk("s1_addr2", mem_addr, 32'h8);
    chk("s1_pc1", inst_pc, 32'h4);

    // 2: three stall cycles while 0x8 is presented
    cyc(0, 1, 0, 0, 1);
    chk("s2_pc", inst_pc, 32'h8);
    chk("s2_ce", inst_CE, 1);
    chk("s2_sel0", inst_sel, 0);
    chk("s2_req0", mem_req, 0);
    cyc(0, 1, 0, 0, 1);
    chk("s2_ce1", inst_CE, 0);
    chk("s2_sel1", inst_sel, 1);
    chk("s2_req1", mem_req, 0);
    cyc(0, 1, 0, 0, 1);
    chk("s2_sel2", inst_sel, 1);
    chk("s2_pc2", inst_pc, 32'h8);
    cyc(0, 0, 0, 0, 1);
    chk("s2_sel3", inst_sel, 1);
    chk("s2_req3", mem_req, 1);
    chk("s2_addr3", mem_addr, 32'hC);
    chk("s2_valid3", inst_valid, 1);

    // 3: no grant for two cycles at 0x10
    cyc(0, 0, 0, 0, 0);
    chk("s3_pcC", inst_pc, 32'hC);
    chk("s3_selC", inst_sel, 0);
    chk("s3_addr0", mem_addr, 32'h10);
    cyc(0, 0, 0, 0, 0);
    chk("s3_valid1", inst_valid, 0);
    chk("s3_addr1", mem_addr, 32'h10);
    cyc(0, 0, 0, 0, 1);
    chk("s3_valid2", inst_valid, 0);
    chk("s3_addr2", mem_addr, 32'h10);
    cyc(0, 0, 0, 0, 1);
    chk("s3_pc", inst_pc, 32'h10);
    chk("s3_valid3", inst_valid, 1);

    // 4: jump during HOLD with stall still high
    cyc(0, 1, 0, 0, 1);
    chk("s4_ce", inst_CE, 1);
    cyc(0, 1, 1, 32'h100, 1);
    chk("s4_valid_kill", inst_valid, 0);
    chk("s4_addr", mem_addr, 32'h100);
    cyc(0, 0, 0, 0, 1);
    chk("s4_sel", inst_sel, 0);
    chk("s4_valid", inst_valid, 1);
    chk("s4_pc", inst_pc, 32'h100);

    // 5: jump without grant, retry, then wrap-around target
    cyc(0, 0, 1, 32'h100, 0);
    chk("s5_kill", inst_valid, 0);
    cyc(0, 0, 0, 0, 1);
    chk("s5_retry", mem_addr, 32'h100);
    chk("s5_req", mem_req, 1);
    cyc(0, 0, 0, 0, 1);
    chk("s5_pc", inst_pc, 32'h100);
    cyc(0, 0, 1, 32'hFFFF_FFFC, 1);
    chk("s5_jaddr", mem_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 1);
    chk("s5_pcwrap", inst_pc, 32'hFFFF_FFFC);
    chk("s5_addrwrap", mem_addr, 32'h0);
    cyc(0, 0, 0, 0, 1);
    chk("s5_pc0", inst_pc, 32'h0);

    // 6: reset asserted in the middle of a HOLD
    cyc(0, 1, 0, 0, 1);
    cyc(0, 1, 0, 0, 1);
    chk("s6_hold", inst_sel, 1);
    cyc(1, 1, 0, 0, 1);
    chk("s6_rsel", inst_sel, 0);
    chk("s6_rvalid", inst_valid, 0);
    chk("s6_rreq", mem_req, 0);
    cyc(0, 0, 0, 0, 1);
    chk("s6_sel", inst_sel, 0);
    chk("s6_valid", inst_valid, 0);
    chk("s6_addr", mem_addr, RPC);
    chk("s6_req", mem_req, 1);
    cyc(0, 0, 0, 0, 1);
    chk("s6_pc", inst_pc, RPC);

    // Mixed traffic checked by the model only
    for (int i = 0; i < 60; i++) begin
      cyc(0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
          {$urandom_range(0, 255), 2'b00}, ($urandom_range(0, 3) != 0));
    end
    cyc(0, 0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
